// File: rtl/mem_copy_engine_if.sv
// rtl/mem_copy_engine_if.sv - command and memory-port bundle for mem_copy_engine (optional checksum under MEMCPY_CHECKSUM_EN)
interface mem_copy_engine_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int LW = 16
);
    logic          start;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    logic          abort;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [DW-1:0] mem_rd;
    logic          busy;
    logic          done;
`ifdef MEMCPY_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    // Copy engine side: takes commands and read data, drives the memory port
    modport master (
        input  start,
        input  src,
        input  dst,
        input  len,
        input  abort,
        input  mem_rd,
        output mem_a,
        output mem_wd,
        output mem_we,
        output busy,
`ifdef MEMCPY_CHECKSUM_EN
        output checksum,
`endif
        output done
    );

    // Host and memory side
    modport slave (
        output start,
        output src,
        output dst,
        output len,
        output abort,
        output mem_rd,
        input  mem_a,
        input  mem_wd,
        input  mem_we,
        input  busy,
`ifdef MEMCPY_CHECKSUM_EN
        input  checksum,
`endif
        input  done
    );
endinterface

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - two-cycle-per-word block copy master (optional checksum under MEMCPY_CHECKSUM_EN)
module mem_copy_engine #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int LW = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    mem_copy_engine_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    r_state;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [AW-1:0] r_mem_a;
    logic [LW-1:0] r_cnt;
    logic [DW-1:0] r_data;
    logic          r_abort;

    // Sequencer: alternates READ/WRITE per word; the address register is loaded
    // one edge early so mem_a is a pure register and holds in IDLE/DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_mem_a <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_abort <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_abort <= 1'b0;
                    if (bus.start) begin
                        r_src <= bus.src;
                        r_dst <= bus.dst;
                        r_cnt <= bus.len;
                        if (bus.len != '0) begin
                            r_state <= S_READ;
                            r_mem_a <= bus.src;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    r_data  <= bus.mem_rd;
                    r_mem_a <= r_dst;
                    if (bus.abort) begin
                        r_abort <= 1'b1;
                    end
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_src <= r_src + 1'b1;
                    r_dst <= r_dst + 1'b1;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == LW'(1) || bus.abort || r_abort) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_READ;
                        r_mem_a <= r_src + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MEMCPY_CHECKSUM_EN
    logic [DW-1:0] r_checksum;

    // Running sum of every word actually written; restarts on each accepted command
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_checksum <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_checksum <= '0;
        end else if (r_state == S_WRITE) begin
            r_checksum <= r_checksum + r_data;
        end
    end

    assign bus.checksum = r_checksum;
`endif

    // Write data is the captured read word; it only changes at a READ edge
    assign bus.mem_a  = r_mem_a;
    assign bus.mem_wd = r_data;
    assign bus.mem_we = (r_state == S_WRITE);
    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = (r_state == S_DONE);
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - scoreboard bench for mem_copy_engine
module tb_mem_copy_engine;
    logic clk;
    logic rst_n;
    int   cyc;
    int   c0;
    int   n_checks;
    int   n_fail;

    typedef struct {
        bit          is_done;
        int          at;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;
    ev_t sb[$];

    logic [31:0] mem [256];
    logic        pl_en;
    logic [7:0]  pl_a;
    logic [31:0] pl_d;

    mem_copy_engine_if #(.AW(32), .DW(32), .LW(16)) bus ();

    mem_copy_engine #(.AW(32), .DW(32), .LW(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb bus.mem_rd = mem[bus.mem_a[7:0]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (bus.mem_we) mem[bus.mem_a[7:0]] <= bus.mem_wd;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write or done pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && (bus.mem_we || bus.done)) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {31'd0, bus.mem_we, bus.mem_a}, 64'd0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("ev_kind", {63'd0, bus.done}, {63'd0, e.is_done});
                chk("ev_cycle", 64'(cyc), 64'(e.at));
                if (!e.is_done) begin
                    chk("ev_addr", {32'd0, bus.mem_a}, {32'd0, e.a});
                    chk("ev_data", {32'd0, bus.mem_wd}, {32'd0, e.d});
                end
            end
        end
    end

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        pl_en = 1'b1;
        pl_a  = a;
        pl_d  = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic exp_w(input int rel, input logic [31:0] a, input logic [31:0] d);
        sb.push_back('{is_done: 1'b0, at: c0 + rel, a: a, d: d});
    endtask

    task automatic exp_done(input int rel);
        sb.push_back('{is_done: 1'b1, at: c0 + rel, a: 32'd0, d: 32'd0});
    endtask

    // Called at a negedge right after c0 = cyc; returns at the negedge of cycle 1
    task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        bus.start = 1'b1;
        bus.src   = s;
        bus.dst   = d;
        bus.len   = l;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic goto(input int n);
        int guard;
        guard = 0;
        while (cyc < c0 + n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; c0 = 0; n_checks = 0; n_fail = 0;
        rst_n = 1'b0; pl_en = 1'b0; pl_a = '0; pl_d = '0;
        bus.start = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0; bus.abort = 1'b0;

        for (int i = 0; i < 4; i++) poke(8'(10 + i), 32'hA + 32'(i));
        poke(8'd6, 32'h66);
        for (int i = 0; i < 8; i++) poke(8'(100 + i), 32'h100 + 32'(i));
        poke(8'd152, 32'hBEEF0152);
        poke(8'd255, 32'h55);
        poke(8'd0, 32'h77);
        for (int i = 0; i < 6; i++) poke(8'(200 + i), 32'h200 + 32'(i));
        poke(8'd62, 32'hDEAD0062);
        poke(8'd63, 32'hDEAD0063);

        @(negedge clk);
        chk("rst_mem_a", {32'd0, bus.mem_a}, 64'd0);
        chk("rst_mem_wd", {32'd0, bus.mem_wd}, 64'd0);
        chk("rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
`ifdef MEMCPY_CHECKSUM_EN
        chk("rst_checksum", {32'd0, bus.checksum}, 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 4-word copy 10..13 -> 40..43
        c0 = cyc;
        exp_w(2, 40, 32'hA); exp_w(4, 41, 32'hB); exp_w(6, 42, 32'hC); exp_w(8, 43, 32'hD);
        exp_done(9);
        run_cmd(10, 40, 4);
        for (int n = 1; n <= 10; n++) begin
            goto(n);
            chk($sformatf("t1_busy_c%0d", n), {63'd0, bus.busy}, {63'd0, (n <= 9)});
        end
        chk("t1_mem40", {32'd0, mem[40]}, 64'hA);
        chk("t1_mem43", {32'd0, mem[43]}, 64'hD);
`ifdef MEMCPY_CHECKSUM_EN
        chk("t1_checksum", {32'd0, bus.checksum}, 64'h2E);
`endif

        // Zero-length command: done in cycle 1, no access
        @(negedge clk);
        c0 = cyc;
        exp_done(1);
        run_cmd(5, 6, 0);
        chk("t2_busy_c1", {63'd0, bus.busy}, 64'd1);
        goto(2);
        chk("t2_busy_c2", {63'd0, bus.busy}, 64'd0);
        chk("t2_mem6", {32'd0, mem[6]}, 64'h66);
`ifdef MEMCPY_CHECKSUM_EN
        chk("t2_checksum", {32'd0, bus.checksum}, 64'd0);
`endif

        // Abort during second READ: two words written, done in cycle 5
        @(negedge clk);
        c0 = cyc;
        exp_w(2, 150, 32'h100); exp_w(4, 151, 32'h101); exp_done(5);
        run_cmd(100, 150, 8);
        goto(3);
        bus.abort = 1'b1;
        goto(4);
        bus.abort = 1'b0;
        goto(7);
        chk("t3_busy_after", {63'd0, bus.busy}, 64'd0);
        chk("t3_mem152", {32'd0, mem[152]}, 64'hBEEF0152);

        // Address wrap from all-ones to zero
        c0 = cyc;
        exp_w(2, 32'h20, 32'h55); exp_w(4, 32'h21, 32'h77); exp_done(5);
        run_cmd(32'hFFFF_FFFF, 32'h20, 2);
        chk("t4_rd_addr0", {32'd0, bus.mem_a}, 64'hFFFF_FFFF);
        goto(3);
        chk("t4_rd_addr1", {32'd0, bus.mem_a}, 64'h0);
        goto(6);

        // Reset during WRITE of word 3 of 6
        c0 = cyc;
        exp_w(2, 60, 32'h200); exp_w(4, 61, 32'h201);
        run_cmd(200, 60, 6);
        goto(5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_we_in_rst", {63'd0, bus.mem_we}, 64'd0);
        chk("t5_busy_in_rst", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_busy_after", {63'd0, bus.busy}, 64'd0);
        chk("t5_mem62", {32'd0, mem[62]}, 64'hDEAD0062);
        chk("t5_mem63", {32'd0, mem[63]}, 64'hDEAD0063);

        // start while busy is ignored; next start after DONE is accepted
        c0 = cyc;
        exp_w(2, 80, 32'hA); exp_w(4, 81, 32'hB); exp_done(5);
        run_cmd(10, 80, 2);
        goto(2);
        bus.start = 1'b1; bus.src = 13; bus.dst = 90; bus.len = 5;
        goto(3);
        bus.start = 1'b0;
        goto(6);
        chk("t6_idle_busy", {63'd0, bus.busy}, 64'd0);
        c0 = cyc;
        exp_w(2, 90, 32'hC); exp_done(3);
        run_cmd(12, 90, 1);
        goto(5);
        chk("t6_mem81", {32'd0, mem[81]}, 64'hB);
        chk("t6_mem90", {32'd0, mem[90]}, 64'hC);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
